gate_stim_sequencer: RTL and testbench

//  Clocked stimulus controller for a gate-level DUT with two inputs (A, B) and one output (OUT).

---
 rtl/gate_stim_if.sv | 39 +++
 rtl/gate_stim_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_gate_stim_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/gate_stim_if.sv
// Purpose : handshake/bus bundle between the host side and gate_stim_sequencer.
// Latency : n/a (wiring only).
// Backpressure: none; start is accepted only when the sequencer is idle and is otherwise dropped.
//
// Ports (signals carried):
//   start, abort, mode[1:0], gap[GAP_W-1:0] : host -> sequencer controls
//   out_i                                   : gate DUT OUT, asynchronous to clk
//   a_o, b_o                                : registered drive of DUT inputs A/B
//   busy, done, pass                        : case status
//   case_cnt, fail_cnt                      : saturating case statistics
interface gate_stim_if #(
  parameter int GAP_W = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [1:0]       mode;
  logic [GAP_W-1:0] gap;
  logic             out_i;
  logic             a_o;
  logic             b_o;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] case_cnt;
  logic [CNT_W-1:0] fail_cnt;

  // Host / bench side: drives controls and the DUT output, observes status.
  modport master (
    output start, abort, mode, gap, out_i,
    input  a_o, b_o, busy, done, pass, case_cnt, fail_cnt
  );

  // Sequencer side.
  modport slave (
    input  start, abort, mode, gap, out_i,
    output a_o, b_o, busy, done, pass, case_cnt, fail_cnt
  );
endinterface

// File: rtl/gate_stim_sequencer.sv
// Purpose : drives gate DUT inputs A/B through a programmed two-edge sequence and scores OUT vs AND.
// Latency : start->done = 1 + SETTLE + 1 + gap + CHECK_DLY cycles (gap 0 behaves as 1).
// Backpressure: start is ignored while busy; abort cancels a running case without a done pulse.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active-high
//   bus  : gate_stim_if.slave (controls in, A/B drive and status out)
//
// Case timeline, edges counted from the start-accept edge (edge 0):
//   edge 0                 : baseline A/B loaded, busy rises
//   edge SETTLE+1          : first edge (trigger)
//   edge SETTLE+1+gap      : second edge (perturb)
//   edge SETTLE+2+gap+CHK  : done pulse, A/B return to 0, busy falls
module gate_stim_sequencer #(
  parameter int GAP_W     = 4,
  parameter int SETTLE    = 4,
  parameter int CHECK_DLY = 3,
  parameter int SYNC_STG  = 2,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  gate_stim_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_EDGE1,
    S_GAP,
    S_EDGE2,
    S_CHECK
  } state_t;

  localparam logic [1:0] M_CLEAN   = 2'd0;
  localparam logic [1:0] M_SETUP_A = 2'd1;
  localparam logic [1:0] M_HOLD_A  = 2'd2;
  localparam logic [1:0] M_HOLD_B  = 2'd3;

  // One shared down-counter serves the settle, gap and check phases; size it
  // for the largest of the three loads.
  localparam int GMAX  = (1 << GAP_W);
  localparam int CMAX0 = (SETTLE > CHECK_DLY) ? SETTLE : CHECK_DLY;
  localparam int CMAX  = (CMAX0 > GMAX) ? CMAX0 : GMAX;
  localparam int CW    = $clog2(CMAX + 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_mode;
  logic [GAP_W-1:0] r_gap;
  logic [SYNC_STG-1:0] r_sync;
  logic             r_a;
  logic             r_b;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_case_cnt;
  logic [CNT_W-1:0] r_fail_cnt;

  logic             w_out_s;
  logic             w_exp;
  logic             w_match;
  logic [CNT_W-1:0] w_case_inc;
  logic [CNT_W-1:0] w_fail_inc;

  // OUT arrives from the gate DUT with no timing relationship to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STG-2:0], bus.out_i};
    end
  end

  assign w_out_s = r_sync[SYNC_STG-1];

  // Cases that leave both inputs high at the end expect OUT=1; hold-violation
  // cases drop one input after the trigger, so a correct AND reads 0.
  assign w_exp   = (r_mode == M_CLEAN) || (r_mode == M_SETUP_A);
  assign w_match = (w_out_s == w_exp);

  // Saturating increments: stick at all-ones instead of wrapping.
  assign w_case_inc = (&r_case_cnt) ? r_case_cnt : r_case_cnt + 1'b1;
  assign w_fail_inc = (&r_fail_cnt) ? r_fail_cnt : r_fail_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_mode     <= M_CLEAN;
      r_gap      <= '0;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_case_cnt <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_done <= 1'b0;

      // Abort outranks every running state, including the sample cycle of
      // CHECK. In IDLE it is ignored so a simultaneous start still launches.
      if ((r_state != S_IDLE) && bus.abort) begin
        r_state <= S_IDLE;
        r_a     <= 1'b0;
        r_b     <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_mode  <= bus.mode;
              r_gap   <= (bus.gap == '0) ? GAP_W'(1) : bus.gap;
              r_busy  <= 1'b1;
              // Baseline: SETUP_A starts with both low; the others start
              // with A high so the trigger on B produces the OUT rise.
              r_a     <= (bus.mode != M_SETUP_A);
              r_b     <= 1'b0;
              r_cnt   <= CW'(SETTLE - 1);
              r_state <= S_SETTLE;
            end
          end

          S_SETTLE: begin
            if (r_cnt == '0) begin
              r_state <= S_EDGE1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end

          S_EDGE1: begin
            if (r_mode == M_SETUP_A) begin
              r_a <= 1'b1;
            end else begin
              r_b <= 1'b1;
            end
            // EDGE2 applies its update on the edge after it is entered, so
            // the GAP phase lasts gap-1 cycles; gap==1 skips GAP entirely.
            if (r_gap == GAP_W'(1)) begin
              r_state <= S_EDGE2;
            end else begin
              r_cnt   <= CW'(r_gap) - CW'(2);
              r_state <= S_GAP;
            end
          end

          S_GAP: begin
            if (r_cnt == '0) begin
              r_state <= S_EDGE2;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end

          S_EDGE2: begin
            case (r_mode)
              M_SETUP_A: r_b <= 1'b1;
              M_HOLD_A:  r_a <= 1'b0;
              M_HOLD_B:  r_b <= 1'b0;
              default:   ;
            endcase
            // Wait CHECK_DLY whole cycles, then sample on the following edge.
            r_cnt   <= CW'(CHECK_DLY);
            r_state <= S_CHECK;
          end

          S_CHECK: begin
            if (r_cnt == '0) begin
              r_done     <= 1'b1;
              r_pass     <= w_match;
              r_case_cnt <= w_case_inc;
              if (!w_match) begin
                r_fail_cnt <= w_fail_inc;
              end
              r_busy  <= 1'b0;
              r_a     <= 1'b0;
              r_b     <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.a_o      = r_a;
  assign bus.b_o      = r_b;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.pass     = r_pass;
  assign bus.case_cnt = r_case_cnt;
  assign bus.fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_gate_stim_sequencer.sv
// Purpose : self-checking bench for gate_stim_sequencer with a behavioural gate DUT model.
// Latency : n/a.
// Backpressure: n/a.
module tb_gate_stim_sequencer;

  localparam int GAP_W     = 4;
  localparam int SETTLE    = 4;
  localparam int CHECK_DLY = 3;
  localparam int SYNC_STG  = 2;
  localparam int CNT_W     = 8;
  localparam int SAT       = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   tb_om;   // gate model: 0 ideal AND, 1 stuck-at-1, 2 stuck-at-0, 3 inverted AND

  int checks = 0;
  int errors = 0;

  // Reference bookkeeping for the statistics outputs.
  int m_case = 0;
  int m_fail = 0;
  int m_pass = 0;

  gate_stim_if #(.GAP_W(GAP_W), .CNT_W(CNT_W)) bus ();

  assign bus.out_i = (tb_om == 1) ? 1'b1 :
                     (tb_om == 2) ? 1'b0 :
                     (tb_om == 3) ? ~(bus.a_o & bus.b_o) :
                                     (bus.a_o & bus.b_o);

  gate_stim_sequencer #(
    .GAP_W(GAP_W), .SETTLE(SETTLE), .CHECK_DLY(CHECK_DLY),
    .SYNC_STG(SYNC_STG), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Runs one case starting at the next rising edge (edge 0) and checks the
  // A/B/busy/done pins after every edge against a timeline derived from the
  // mode rules. abort_at>0: abort seen at that edge; abort_at<0: abort raised
  // together with start in IDLE. chain: start held high through the done edge
  // so the following call's edge 0 is the first edge after done.
  task automatic run_case(input logic [1:0] m, input int g, input int om,
                          input int abort_at, input bit restart, input bit chain,
                          output int lat, output int opass);
    int g1, e1, e2, d, tend;
    bit ba, bb, a1, b1, a2, b2, exp_out, outv;
    bit ea, eb, ebusy, edone;
    g1   = (g == 0) ? 1 : g;
    e1   = SETTLE + 1;
    e2   = e1 + g1;
    d    = e2 + CHECK_DLY + 1;
    tend = (abort_at > 0) ? abort_at : (chain ? d : d + 1);
    // Pin values after each phase, straight from the mode descriptions.
    ba = (m != 2'd1); bb = 1'b0;
    a1 = 1'b1;        b1 = (m != 2'd1) ? 1'b1 : 1'b0;
    case (m)
      2'd0:    begin a2 = 1'b1; b2 = 1'b1; end
      2'd1:    begin a2 = 1'b1; b2 = 1'b1; end
      2'd2:    begin a2 = 1'b0; b2 = 1'b1; end
      default: begin a2 = 1'b1; b2 = 1'b0; end
    endcase
    exp_out = (m == 2'd0) || (m == 2'd1);
    lat = -1; opass = -1;
    tb_om     = om;
    bus.start = 1'b1;
    bus.mode  = m;
    bus.gap   = GAP_W'(g);
    bus.abort = (abort_at < 0);
    for (int t = 0; t <= tend; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (abort_at > 0 && t >= abort_at) begin
        ea = 0; eb = 0; ebusy = 0; edone = 0;
      end else if (t < e1) begin
        ea = ba; eb = bb; ebusy = 1; edone = 0;
      end else if (t < e2) begin
        ea = a1; eb = b1; ebusy = 1; edone = 0;
      end else if (t < d) begin
        ea = a2; eb = b2; ebusy = 1; edone = 0;
      end else if (t == d) begin
        ea = 0; eb = 0; ebusy = 0; edone = 1;
      end else begin
        ea = 0; eb = 0; ebusy = 0; edone = 0;
      end
      chk($sformatf("pins{a,b,busy,done} m%0d g%0d t%0d", m, g, t),
          int'({bus.a_o, bus.b_o, bus.busy, bus.done}),
          int'({ea, eb, ebusy, edone}));
      if (bus.done) begin
        lat   = t;
        opass = int'(bus.pass);
      end
      bus.start = (restart && t == 2) || (chain && t >= d - 1);
      if (restart && t == 2) begin
        bus.mode = 2'($urandom);
        bus.gap  = GAP_W'($urandom);
      end
      bus.abort = (abort_at > 0) && (t == abort_at - 1);
    end
    bus.abort = 1'b0;
    if (!chain) bus.start = 1'b0;
    if (abort_at <= 0) begin
      case (om)
        0:       outv = a2 & b2;
        1:       outv = 1'b1;
        2:       outv = 1'b0;
        default: outv = ~(a2 & b2);
      endcase
      m_pass = (outv == exp_out) ? 1 : 0;
      if (m_case < SAT) m_case++;
      if (m_pass == 0 && m_fail < SAT) m_fail++;
    end
    chk("pass", int'(bus.pass), m_pass);
    chk("case_cnt", int'(bus.case_cnt), m_case);
    chk("fail_cnt", int'(bus.fail_cnt), m_fail);
  endtask

  typedef struct {
    logic [1:0] m;
    int         g;
    int         om;
    int         ab;
    bit         rs;
    bit         ch;
    int         lat;   // expected done edge, -1 when no done
    int         pas;   // expected pass at done, -1 when no done
  } vec_t;

  vec_t tbl[11];

  initial begin
    int lat, op, ab, dd, gg;
    logic [1:0] mm;
    bit rs, ch;

    tbl[0]  = '{2'd0, 5, 0,  0, 1'b0, 1'b0, 14,  1};  // CLEAN gap5
    tbl[1]  = '{2'd2, 2, 0,  0, 1'b0, 1'b0, 11,  1};  // HOLD_A gap2
    tbl[2]  = '{2'd2, 2, 1,  0, 1'b0, 1'b0, 11,  0};  // HOLD_A stuck-at-1
    tbl[3]  = '{2'd3, 0, 0,  0, 1'b0, 1'b0, 10,  1};  // HOLD_B gap0 -> 1
    tbl[4]  = '{2'd1, 3, 0,  0, 1'b1, 1'b0, 12,  1};  // SETUP_A, restart while busy
    tbl[5]  = '{2'd0, 4, 0,  7, 1'b0, 1'b0, -1, -1};  // abort in GAP
    tbl[6]  = '{2'd0, 1, 0,  0, 1'b0, 1'b1, 10,  1};  // start held through done
    tbl[7]  = '{2'd1, 2, 0,  0, 1'b0, 1'b0, 11,  1};  // accepted right after done
    tbl[8]  = '{2'd3, 3, 0, 12, 1'b0, 1'b0, -1, -1};  // abort on CHECK sample edge
    tbl[9]  = '{2'd0, 2, 2,  0, 1'b0, 1'b0, 11,  0};  // CLEAN stuck-at-0
    tbl[10] = '{2'd0, 3, 0, -1, 1'b0, 1'b0, 12,  1};  // abort with start in IDLE

    tb_om = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 2'd0; bus.gap = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset pins", int'({bus.a_o, bus.b_o, bus.busy, bus.done, bus.pass}), 0);
    chk("reset counters", int'({bus.case_cnt, bus.fail_cnt}), 0);

    foreach (tbl[i]) begin
      run_case(tbl[i].m, tbl[i].g, tbl[i].om, tbl[i].ab, tbl[i].rs, tbl[i].ch, lat, op);
      chk($sformatf("tbl%0d latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d pass", i), op, tbl[i].pas);
    end

    // Reset in the middle of a HOLD_A case, applied between clock edges.
    tb_om = 0;
    bus.start = 1'b1; bus.mode = 2'd2; bus.gap = 4'd2;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset busy", int'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid-case reset pins", int'({bus.a_o, bus.b_o, bus.busy, bus.done, bus.pass}), 0);
    chk("mid-case reset counters", int'({bus.case_cnt, bus.fail_cnt}), 0);
    @(negedge clk);
    rst = 1'b0;
    m_case = 0; m_fail = 0; m_pass = 0;

    // Randomized cases.
    for (int i = 0; i < 40; i++) begin
      mm = 2'($urandom);
      gg = $urandom_range(0, 15);
      dd = SETTLE + 1 + ((gg == 0) ? 1 : gg) + CHECK_DLY + 1;
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, dd) : 0;
      rs = ($urandom_range(0, 1) == 1);
      ch = (ab == 0) && (i < 39) && ($urandom_range(0, 3) == 0);
      run_case(mm, gg, $urandom_range(0, 3), ab, rs, ch, lat, op);
    end

    // Forced failures until both counters pin at all-ones.
    for (int i = 0; i < 256; i++) begin
      run_case(2'd2, 1, 1, 0, 1'b0, 1'b0, lat, op);
    end
    chk("fail_cnt saturated", int'(bus.fail_cnt), 255);
    chk("case_cnt saturated", int'(bus.case_cnt), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
